// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-requester SRAM arbiter: response-owner encoding
// and requester indices used to slice the req/gnt vectors.
package sram_arb_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    localparam int REQ_D = 0;
    localparam int REQ_I = 1;

    typedef enum logic [1:0] {
        RESP_NONE = OWN_NONE,
        RESP_INST = OWN_INST,
        RESP_DATA = OWN_DATA
    } resp_owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On contention the requester that did not win
// last time is chosen; last_grant only moves when a grant is issued.
module rr_arb2 #(
    parameter logic INIT_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // last_grant holds the index of the previous winner (1 = inst, 0 = data)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant <= INIT_PRIO;
        else if (advance)
            last_grant <= gnt[1];
    end

endmodule

// File: rtl/sram_arbiter.sv
// Pipelined round-robin arbiter sharing one single-port SRAM between the
// instruction and data ports. Optional counters under SRAM_ARB_PERF_EN.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int SRAM_AW   = 12,
    parameter int INIT_PRIO = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [3:0]         i_wen,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_wdata,
    output logic               i_addr_ok,
    output logic               i_data_ok,
    output logic [31:0]        i_rdata,
    input  logic               d_req,
    input  logic [3:0]         d_wen,
    input  logic [31:0]        d_addr,
    input  logic [31:0]        d_wdata,
    output logic               d_addr_ok,
    output logic               d_data_ok,
    output logic [31:0]        d_rdata,
    output logic               sram_en,
    output logic [3:0]         sram_wen,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_i_grants,
    output logic [31:0]        perf_d_grants,
    output logic [31:0]        perf_conflicts
`endif
);

    logic [1:0]  req;
    logic [1:0]  gnt;
    resp_owner_e resp_owner, resp_owner_nxt;

    // Requests are masked while reset is held so no addr_ok escapes during reset
    assign req[REQ_D] = d_req & reset;
    assign req[REQ_I] = i_req & reset;

    rr_arb2 #(.INIT_PRIO(INIT_PRIO != 0)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (|gnt),
        .gnt     (gnt)
    );

    assign i_addr_ok = gnt[REQ_I];
    assign d_addr_ok = gnt[REQ_D];

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'h0;
        sram_addr  = '0;
        sram_wdata = 32'h0;
        if (gnt[REQ_I]) begin
            sram_en    = 1'b1;
            sram_wen   = i_wen;
            sram_addr  = i_addr[SRAM_AW+1:2];
            sram_wdata = i_wdata;
        end else if (gnt[REQ_D]) begin
            sram_en    = 1'b1;
            sram_wen   = d_wen;
            sram_addr  = d_addr[SRAM_AW+1:2];
            sram_wdata = d_wdata;
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:SRAM_AW+2], i_addr[1:0],
                                d_addr[31:SRAM_AW+2], d_addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            resp_owner <= RESP_NONE;
        else
            resp_owner <= resp_owner_nxt;
    end

    always_comb begin
        resp_owner_nxt = RESP_NONE;
        if (gnt[REQ_I])
            resp_owner_nxt = RESP_INST;
        else if (gnt[REQ_D])
            resp_owner_nxt = RESP_DATA;
    end

    // Response is a pure function of the registered owner: never stalls
    assign i_data_ok = (resp_owner == RESP_INST);
    assign d_data_ok = (resp_owner == RESP_DATA);
    assign i_rdata   = sram_rdata;
    assign d_rdata   = sram_rdata;

`ifdef SRAM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_i_grants  <= 32'h0;
            perf_d_grants  <= 32'h0;
            perf_conflicts <= 32'h0;
        end else begin
            if (gnt[REQ_I]) perf_i_grants  <= perf_i_grants + 32'd1;
            if (gnt[REQ_D]) perf_d_grants  <= perf_d_grants + 32'd1;
            if (&req)       perf_conflicts <= perf_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 1-cycle SRAM model.
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req;
    logic [3:0]  i_wen, d_wen;
    logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef SRAM_ARB_PERF_EN
        , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    // SRAM model: byte-merge writes, 1-cycle read latency
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (sram_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_wen[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            sram_rdata <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_wen = 0; i_addr = 0; i_wdata = 0;
        d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = (k < 8) ? k : 32'h0;
        sram_rdata = 32'h0;
        reset = 1'b0;
        idle_inputs();
        d_req = 1;
        #2;
        check("rst_addr_ok", {30'h0, i_addr_ok, d_addr_ok}, 32'h0);
        check("rst_data_ok", {30'h0, i_data_ok, d_data_ok}, 32'h0);
        check("rst_sram", {27'h0, sram_en, sram_wen}, 32'h0);
`ifdef SRAM_ARB_PERF_EN
        check("rst_perf", perf_i_grants | perf_d_grants | perf_conflicts, 32'h0);
`endif
        d_req = 0;
        step(); step();
        reset = 1'b1;
        step();

        // contention from reset: I, D, I, D, I, D
        i_req = 1; i_addr = 32'h20; d_req = 1; d_addr = 32'h40;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("cont_i_aok%0d", c), {31'h0, i_addr_ok}, {31'h0, c % 2 == 0});
            check($sformatf("cont_d_aok%0d", c), {31'h0, d_addr_ok}, {31'h0, c % 2 == 1});
            if (c > 0) begin
                check($sformatf("cont_i_dok%0d", c), {31'h0, i_data_ok}, {31'h0, c % 2 == 1});
                check($sformatf("cont_d_dok%0d", c), {31'h0, d_data_ok}, {31'h0, c % 2 == 0});
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("cont_last_dok", {30'h0, i_data_ok, d_data_ok}, 32'h1);
        check("cont_last_rdata", d_rdata, 32'h0);
`ifdef SRAM_ARB_PERF_EN
        check("perf_i", perf_i_grants, 32'd3);
        check("perf_d", perf_d_grants, 32'd3);
        check("perf_conf", perf_conflicts, 32'd6);
`endif
        step();

        // single-requester streaming reads of mem[0..7]
        for (int c = 0; c <= 8; c++) begin
            i_req = (c < 8); i_addr = 32'(4 * c);
            @(negedge clk);
            if (c < 8) check($sformatf("strm_aok%0d", c), {31'h0, i_addr_ok}, 32'h1);
            if (c > 0) begin
                check($sformatf("strm_dok%0d", c), {31'h0, i_data_ok}, 32'h1);
                check($sformatf("strm_rdata%0d", c), i_rdata, 32'(c - 1));
            end
            step();
        end
        idle_inputs();

        // read-after-write, then partial write and aliased read
        d_req = 1; d_wen = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wr_aok", {31'h0, d_addr_ok}, 32'h1);
        check("wr_sram_en", {31'h0, sram_en}, 32'h1);
        check("wr_sram_addr", {20'h0, sram_addr}, 32'h004);
        check("wr_sram_wen", {28'h0, sram_wen}, 32'hF);
        check("wr_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
        step();
        idle_inputs();
        i_req = 1; i_addr = 32'h10;
        @(negedge clk);
        check("wr_dok", {31'h0, d_data_ok}, 32'h1);
        check("raw_aok", {31'h0, i_addr_ok}, 32'h1);
        step();
        idle_inputs();
        d_req = 1; d_wen = 4'h3; d_addr = 32'h10; d_wdata = 32'h1234_5678;
        @(negedge clk);
        check("raw_dok", {31'h0, i_data_ok}, 32'h1);
        check("raw_rdata", i_rdata, 32'hDEAD_BEEF);
        check("part_wen", {28'h0, sram_wen}, 32'h3);
        step();
        idle_inputs();
        i_req = 1; i_addr = 32'hFFFF_C013;
        @(negedge clk);
        check("alias_addr", {20'h0, sram_addr}, 32'h004);
        step();
        idle_inputs();
        @(negedge clk);
        check("alias_rdata", i_rdata, 32'hDEAD_5678);
        step();

        // idle
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d", c), {26'h0, sram_en, sram_wen, i_data_ok, d_data_ok}, 32'h0);
            step();
        end

        // reset between grant and response
        d_req = 1; d_addr = 32'h8;
        @(negedge clk);
        check("mid_aok", {31'h0, d_addr_ok}, 32'h1);
        #1;
        reset = 1'b0;
        d_req = 0;
        @(negedge clk);
        check("mid_dok", {30'h0, i_data_ok, d_data_ok}, 32'h0);
`ifdef SRAM_ARB_PERF_EN
        check("mid_perf_clr", perf_i_grants | perf_d_grants | perf_conflicts, 32'h0);
`endif
        i_req = 1; d_req = 1;
        #1;
        check("mid_rst_aok", {30'h0, i_addr_ok, d_addr_ok}, 32'h0);
        reset = 1'b1;
        #1;
        check("post_rst_grant", {30'h0, i_addr_ok, d_addr_ok}, 32'h2);
        step();
        @(negedge clk);
        check("post_rst_grant2", {30'h0, i_addr_ok, d_addr_ok}, 32'h1);
        check("post_rst_dok", {30'h0, i_data_ok, d_data_ok}, 32'h2);
        step();
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
